// File: rtl/otter_pl_pkg.sv
// Shared types for the OTTER pipeline sequencer: sequencer states, forwarding
// select encoding and the register-match helper used by the forwarding compare.
package otter_pl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_MEM = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

    // x0 is hard-wired to zero, so a write to it must never be forwarded
    function automatic logic regMatch(input logic       regWrite,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
        return regWrite && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/otter_fwd_unit.sv
// Forwarding compare for one EX-stage ALU operand; the younger MEM result
// takes priority over the WB result when both target the same register.
module otter_fwd_unit
    import otter_pl_pkg::*;
(
    input  logic [4:0] rs_addr_EX_i,
    input  logic [4:0] rd_addr_MEM_i,
    input  logic       regWrite_MEM_i,
    input  logic [4:0] rd_addr_WB_i,
    input  logic       regWrite_WB_i,
    output logic [1:0] fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (regMatch(regWrite_MEM_i, rd_addr_MEM_i, rs_addr_EX_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (regMatch(regWrite_WB_i, rd_addr_WB_i, rs_addr_EX_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/otter_pl_hazard_ctrl.sv
// Central sequencer for the 5-stage OTTER pipeline: load-use stalls, redirect
// flushes, EX operand forwarding and the drain-then-trap interrupt entry.
module otter_pl_hazard_ctrl
    import otter_pl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
)
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  rs1_addr_ID_i,
    input  logic [4:0]  rs2_addr_ID_i,
    input  logic        rs1_used_ID_i,
    input  logic        rs2_used_ID_i,
    input  logic [31:0] pc_ID_i,
    input  logic [4:0]  rd_addr_EX_i,
    input  logic        regWrite_EX_i,
    input  logic        memRead2_EX_i,
    input  logic [4:0]  rs1_addr_EX_i,
    input  logic [4:0]  rs2_addr_EX_i,
    input  logic [4:0]  rd_addr_MEM_i,
    input  logic        regWrite_MEM_i,
    input  logic [4:0]  rd_addr_WB_i,
    input  logic        regWrite_WB_i,
    input  logic        redirect_EX_i,
    input  logic        INTR_i,
    input  logic        mie_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic [1:0]  fwd_a_sel_o,
    output logic [1:0]  fwd_b_sel_o,
    output logic        trap_pc_sel_o,
    output logic        intTaken_o,
    output logic [31:0] epc_o
);

    localparam int               CNT_W    = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    hz_state_t        state_q, state_d;
    logic             pend_q, pend_d;
    logic             idValid_q, idValid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      epc_q, epc_d;

    logic       loadUse;
    logic       accept;
    logic       pcStall, ifIdStall, ifIdFlush, idExFlush;
    logic       trapPcSel, intTaken;
    logic [1:0] fwdA, fwdB;

    otter_fwd_unit u_fwd_a (
        .rs_addr_EX_i   (rs1_addr_EX_i),
        .rd_addr_MEM_i  (rd_addr_MEM_i),
        .regWrite_MEM_i (regWrite_MEM_i),
        .rd_addr_WB_i   (rd_addr_WB_i),
        .regWrite_WB_i  (regWrite_WB_i),
        .fwd_sel_o      (fwdA)
    );

    otter_fwd_unit u_fwd_b (
        .rs_addr_EX_i   (rs2_addr_EX_i),
        .rd_addr_MEM_i  (rd_addr_MEM_i),
        .regWrite_MEM_i (regWrite_MEM_i),
        .rd_addr_WB_i   (rd_addr_WB_i),
        .regWrite_WB_i  (regWrite_WB_i),
        .fwd_sel_o      (fwdB)
    );

    // A load result is not ready for EX until it reaches WB, so a dependent ID op waits one cycle
    assign loadUse = memRead2_EX_i && regWrite_EX_i && (rd_addr_EX_i != 5'd0) &&
                     ((rs1_used_ID_i && (rs1_addr_ID_i == rd_addr_EX_i)) ||
                      (rs2_used_ID_i && (rs2_addr_ID_i == rd_addr_EX_i)));

    assign accept = (state_q == RUN) && pend_q && idValid_q && !redirect_EX_i && !loadUse;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        pcStall   = 1'b0;
        ifIdStall = 1'b0;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;
        trapPcSel = 1'b0;
        intTaken  = 1'b0;

        case (state_q)
            RUN: begin
                if (INTR_i && mie_i) begin
                    pend_d = 1'b1;
                end
                if (redirect_EX_i) begin
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                end else if (loadUse) begin
                    pcStall   = 1'b1;
                    ifIdStall = 1'b1;
                    idExFlush = 1'b1;
                end else if (accept) begin
                    // The killed ID instruction is the one mret returns to
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                    epc_d     = pc_ID_i;
                    cnt_d     = '0;
                    state_d   = DRAIN;
                end
            end

            DRAIN: begin
                pcStall   = 1'b1;
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    pend_d  = 1'b0;
                    state_d = TRAP;
                end
            end

            TRAP: begin
                intTaken  = 1'b1;
                trapPcSel = 1'b1;
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
                state_d   = RUN;
            end

            default: begin
                state_d = RUN;
            end
        endcase

        idValid_d = idValid_q;
        if (ifIdFlush) begin
            idValid_d = 1'b0;
        end else if (!ifIdStall) begin
            idValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= RUN;
            pend_q    <= 1'b0;
            idValid_q <= 1'b0;
            cnt_q     <= '0;
            epc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            idValid_q <= idValid_d;
            cnt_q     <= cnt_d;
            epc_q     <= epc_d;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the decoder presents
    assign pc_stall_o    = !reset_i && pcStall;
    assign if_id_stall_o = !reset_i && ifIdStall;
    assign if_id_flush_o = !reset_i && ifIdFlush;
    assign id_ex_flush_o = !reset_i && idExFlush;
    assign trap_pc_sel_o = !reset_i && trapPcSel;
    assign intTaken_o    = !reset_i && intTaken;
    assign fwd_a_sel_o   = reset_i ? FWD_RF : fwdA;
    assign fwd_b_sel_o   = reset_i ? FWD_RF : fwdB;
    assign epc_o         = reset_i ? 32'h0 : epc_q;

endmodule

// File: tb/tb_otter_pl_hazard_ctrl.sv
// Self-checking bench for otter_pl_hazard_ctrl: per-cycle expected outputs are
// queued as stimulus is applied and compared when the combinational outputs settle.
module tb_otter_pl_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1AddrId, rs2AddrId;
    logic        rs1UsedId, rs2UsedId;
    logic [31:0] pcId;
    logic [4:0]  rdAddrEx, rs1AddrEx, rs2AddrEx, rdAddrMem, rdAddrWb;
    logic        regWriteEx, memRead2Ex, regWriteMem, regWriteWb;
    logic        redirectEx, intr, mie;
    logic        pcStall, ifIdStall, ifIdFlush, idExFlush, trapPcSel, intTaken;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] epc;

    typedef struct packed {
        logic [9:0]  vec;
        logic [31:0] epc;
    } exp_t;

    // Output vector: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, fwd_a, fwd_b, trap_pc_sel, intTaken}
    localparam logic [9:0] V_ZERO    = 10'b0000_00_00_00;
    localparam logic [9:0] V_LOADUSE = 10'b1101_00_00_00;
    localparam logic [9:0] V_FLUSH   = 10'b0011_00_00_00;
    localparam logic [9:0] V_DRAIN   = 10'b1011_00_00_00;
    localparam logic [9:0] V_TRAP    = 10'b0011_00_00_11;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    otter_pl_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .rs1_addr_ID_i  (rs1AddrId),
        .rs2_addr_ID_i  (rs2AddrId),
        .rs1_used_ID_i  (rs1UsedId),
        .rs2_used_ID_i  (rs2UsedId),
        .pc_ID_i        (pcId),
        .rd_addr_EX_i   (rdAddrEx),
        .regWrite_EX_i  (regWriteEx),
        .memRead2_EX_i  (memRead2Ex),
        .rs1_addr_EX_i  (rs1AddrEx),
        .rs2_addr_EX_i  (rs2AddrEx),
        .rd_addr_MEM_i  (rdAddrMem),
        .regWrite_MEM_i (regWriteMem),
        .rd_addr_WB_i   (rdAddrWb),
        .regWrite_WB_i  (regWriteWb),
        .redirect_EX_i  (redirectEx),
        .INTR_i         (intr),
        .mie_i          (mie),
        .pc_stall_o     (pcStall),
        .if_id_stall_o  (ifIdStall),
        .if_id_flush_o  (ifIdFlush),
        .id_ex_flush_o  (idExFlush),
        .fwd_a_sel_o    (fwdA),
        .fwd_b_sel_o    (fwdB),
        .trap_pc_sel_o  (trapPcSel),
        .intTaken_o     (intTaken),
        .epc_o          (epc)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outVec();
        return {pcStall, ifIdStall, ifIdFlush, idExFlush, fwdA, fwdB, trapPcSel, intTaken};
    endfunction

    function automatic logic [9:0] fwdVec(input logic [1:0] a, input logic [1:0] b);
        return {4'b0000, a, b, 2'b00};
    endfunction

    task automatic idle();
        rs1AddrId   = 5'd0;
        rs2AddrId   = 5'd0;
        rs1UsedId   = 1'b0;
        rs2UsedId   = 1'b0;
        pcId        = 32'h0;
        rdAddrEx    = 5'd0;
        regWriteEx  = 1'b0;
        memRead2Ex  = 1'b0;
        rs1AddrEx   = 5'd0;
        rs2AddrEx   = 5'd0;
        rdAddrMem   = 5'd0;
        regWriteMem = 1'b0;
        rdAddrWb    = 5'd0;
        regWriteWb  = 1'b0;
        redirectEx  = 1'b0;
        intr        = 1'b0;
        mie         = 1'b0;
    endtask

    // lw x<rd> in EX with an ID consumer of x<rd> in rs1 and x1 in rs2
    task automatic loadUseInputs(input logic [4:0] rd);
        memRead2Ex = 1'b1;
        regWriteEx = 1'b1;
        rdAddrEx   = rd;
        rs1AddrId  = rd;
        rs1UsedId  = 1'b1;
        rs2AddrId  = 5'd1;
        rs2UsedId  = 1'b1;
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [9:0] got;
        for (int i = 0; i < 2; i++) begin
            idle();
            case (i)
                0: begin
                    reset = 1'b1;
                    loadUseInputs(5'd5);
                    rs1AddrEx = 5'd5; rdAddrMem = 5'd5; regWriteMem = 1'b1;
                    expQ.push_back({V_ZERO, 32'h0});
                end
                default: begin
                    reset = 1'b0;
                    expQ.push_back({V_ZERO, 32'h0});
                end
            endcase
            @(negedge clk);
            e   = expQ.pop_front();
            got = outVec();
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("[TB] FAIL reset step %0d outputs: got %b want %b", i, got, e.vec);
            end
            checks++;
            if (epc !== e.epc) begin
                errors++;
                $display("[TB] FAIL reset step %0d epc: got %h want %h", i, epc, e.epc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        exp_t       e;
        logic [9:0] got;
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: begin
                    loadUseInputs(5'd5);
                    expQ.push_back({V_LOADUSE, 32'h0});
                end
                1: begin
                    rs1AddrId = 5'd5; rs1UsedId = 1'b1; rs2AddrId = 5'd1; rs2UsedId = 1'b1;
                    rdAddrMem = 5'd5; regWriteMem = 1'b1;
                    expQ.push_back({V_ZERO, 32'h0});
                end
                2: begin
                    rs1AddrId = 5'd6; rs1UsedId = 1'b1;
                    rs1AddrEx = 5'd5; rs2AddrEx = 5'd1;
                    rdAddrWb  = 5'd5; regWriteWb = 1'b1;
                    expQ.push_back({fwdVec(2'd2, 2'd0), 32'h0});
                end
                3: begin
                    memRead2Ex = 1'b1; regWriteEx = 1'b1; rdAddrEx = 5'd7;
                    rs1AddrId = 5'd7; rs2AddrId = 5'd7;
                    expQ.push_back({V_ZERO, 32'h0});
                end
                4: begin
                    memRead2Ex = 1'b1; regWriteEx = 1'b1; rdAddrEx = 5'd0;
                    rs1AddrId = 5'd0; rs1UsedId = 1'b1;
                    expQ.push_back({V_ZERO, 32'h0});
                end
                default: begin
                    memRead2Ex = 1'b1; regWriteEx = 1'b1; rdAddrEx = 5'd9;
                    rs1AddrId = 5'd2; rs1UsedId = 1'b1; rs2AddrId = 5'd9; rs2UsedId = 1'b1;
                    expQ.push_back({V_LOADUSE, 32'h0});
                end
            endcase
            @(negedge clk);
            e   = expQ.pop_front();
            got = outVec();
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("[TB] FAIL load_use step %0d outputs: got %b want %b", i, got, e.vec);
            end
            checks++;
            if (epc !== e.epc) begin
                errors++;
                $display("[TB] FAIL load_use step %0d epc: got %h want %h", i, epc, e.epc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_forwarding();
        exp_t       e;
        logic [9:0] got;
        logic [4:0] mRd[5]  = '{5'd5, 5'd0, 5'd5, 5'd6, 5'd31};
        logic       mWr[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0] wRd[5]  = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd0};
        logic       wWr[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0] rA[5]   = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd0};
        logic [4:0] rB[5]   = '{5'd5, 5'd0, 5'd6, 5'd6, 5'd31};
        logic [1:0] expA[5] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd0};
        logic [1:0] expB[5] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 5; i++) begin
            idle();
            rdAddrMem = mRd[i]; regWriteMem = mWr[i];
            rdAddrWb  = wRd[i]; regWriteWb  = wWr[i];
            rs1AddrEx = rA[i];  rs2AddrEx   = rB[i];
            expQ.push_back({fwdVec(expA[i], expB[i]), 32'h0});
            @(negedge clk);
            e   = expQ.pop_front();
            got = outVec();
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("[TB] FAIL forwarding vector %0d: got %b want %b", i, got, e.vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_redirect();
        exp_t       e;
        logic [9:0] got;
        for (int i = 0; i < 2; i++) begin
            idle();
            if (i == 0) begin
                loadUseInputs(5'd5);
                redirectEx = 1'b1;
                expQ.push_back({V_FLUSH, 32'h0});
            end else begin
                expQ.push_back({V_ZERO, 32'h0});
            end
            @(negedge clk);
            e   = expQ.pop_front();
            got = outVec();
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("[TB] FAIL redirect step %0d outputs: got %b want %b", i, got, e.vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_interrupt();
        exp_t       e;
        logic [9:0] got;
        for (int i = 0; i < 10; i++) begin
            idle();
            pcId = 32'h100;
            case (i)
                0: begin intr = 1'b1; expQ.push_back({V_ZERO, 32'h0}); end
                1: expQ.push_back({V_ZERO, 32'h0});
                2: begin intr = 1'b1; mie = 1'b1; expQ.push_back({V_ZERO, 32'h0}); end
                3: expQ.push_back({V_FLUSH, 32'h0});
                4, 5, 6: begin intr = 1'b1; mie = 1'b1; expQ.push_back({V_DRAIN, 32'h100}); end
                7: begin intr = 1'b1; mie = 1'b1; expQ.push_back({V_TRAP, 32'h100}); end
                default: expQ.push_back({V_ZERO, 32'h100});
            endcase
            @(negedge clk);
            e   = expQ.pop_front();
            got = outVec();
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("[TB] FAIL interrupt step %0d outputs: got %b want %b", i, got, e.vec);
            end
            checks++;
            if (epc !== e.epc) begin
                errors++;
                $display("[TB] FAIL interrupt step %0d epc: got %h want %h", i, epc, e.epc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_deferred();
        exp_t       e;
        logic [9:0] got;
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: begin pcId = 32'h200; intr = 1'b1; mie = 1'b1; expQ.push_back({V_ZERO, 32'h100}); end
                1: begin pcId = 32'h200; redirectEx = 1'b1; expQ.push_back({V_FLUSH, 32'h100}); end
                2: begin pcId = 32'h300; expQ.push_back({V_ZERO, 32'h100}); end
                3: begin pcId = 32'h340; loadUseInputs(5'd3); expQ.push_back({V_LOADUSE, 32'h100}); end
                4: begin pcId = 32'h340; expQ.push_back({V_FLUSH, 32'h100}); end
                default: expQ.push_back({V_DRAIN, 32'h340});
            endcase
            @(negedge clk);
            e   = expQ.pop_front();
            got = outVec();
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("[TB] FAIL deferred step %0d outputs: got %b want %b", i, got, e.vec);
            end
            checks++;
            if (epc !== e.epc) begin
                errors++;
                $display("[TB] FAIL deferred step %0d epc: got %h want %h", i, epc, e.epc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_drain();
        exp_t       e;
        logic [9:0] got;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) begin
                reset = 1'b1;
                loadUseInputs(5'd4);
            end else begin
                reset = 1'b0;
            end
            expQ.push_back({V_ZERO, 32'h0});
            @(negedge clk);
            e   = expQ.pop_front();
            got = outVec();
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("[TB] FAIL reset_mid_drain step %0d outputs: got %b want %b", i, got, e.vec);
            end
            checks++;
            if (epc !== e.epc) begin
                errors++;
                $display("[TB] FAIL reset_mid_drain step %0d epc: got %h want %h", i, epc, e.epc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        $display("[TB] starting otter_pl_hazard_ctrl bench");
        test_reset();
        test_load_use();
        test_forwarding();
        test_redirect();
        test_interrupt();
        test_deferred();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
